nios2_onchip_memtest_master: RTL
================================

# nios2_onchip_memtest_master

Avalon-MM master that drives the second port (s2) of the dual-port on-chip RAM to fill a word range with a fixed or incrementing pattern, or to read the range back and compare it against the same pattern. It sits beside the Nios II core: the CPU keeps port s1, and this engine owns s2 for boot-time clearing, scrubbing and self-test. The engine issues one bus transfer per cycle, pipelines reads against the RAM's fixed read latency, and reports pass/fail counters.

## Interface
- ADDR_W, 8: word-address width of the RAM port.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1: cycles from read address to readdata valid; legal values 1 or 2.
- clk  in  1  single clock for the engine and the bus.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- mode  in  1  0 = fill, 1 = verify; latched at start.
- base_addr  in  ADDR_W  first word address; latched at start.
- word_count  in  ADDR_W+1  number of words; 0 = no-op; values above 2^ADDR_W saturate to 2^ADDR_W.
- pattern  in  DATA_W  seed data; latched at start.
- incr  in  1  1 = word i uses pattern+i (mod 2^DATA_W); 0 = constant pattern.
- busy  out  1  high from first bus cycle until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky: set on any verify mismatch; cleared by the next accepted start.
- mismatch_count  out  16  verify mismatches, saturating at 16'hFFFF; cleared at start.
- first_fail_addr  out  ADDR_W  address of the first mismatch; cleared at start.
- address  out  ADDR_W  bus word address.
- chipselect  out  1  bus transfer valid.
- write  out  1  1 = write transfer, 0 = read.
- byteenable  out  DATA_W/8  all ones whenever chipselect is high, else 0.
- writedata  out  DATA_W  write data.
- readdata  in  DATA_W  read data, valid READ_LATENCY cycles after the read address.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start with word_count = 0, go directly to DONE (no bus transfers). Otherwise latch the command, go to WRITE (mode 0) or READ (mode 1).
- WRITE: one write per cycle at address base_addr+i (mod 2^ADDR_W, wraps 255->0 for ADDR_W=8), data = expected(i). After the last word, go to DONE.
- READ: one read per cycle; the expected word and address travel down a READ_LATENCY-deep pipeline alongside the request. After the last issue, go to DRAIN.
- DRAIN: hold for READ_LATENCY cycles while the outstanding compares retire, then go to DONE.
- Compare: readdata != expected increments mismatch_count (saturating) and sets error; the first mismatch in a run loads first_fail_addr.
- DONE: pulse done for one cycle, then return to IDLE.
- start while busy or in DONE is ignored. Changes to mode, base_addr, word_count, pattern or incr after start have no effect.
- Reset mid-operation: all state and outputs are cleared immediately, and any bus transfer is abandoned. A partially filled range is acceptable.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- Start is accepted at cycle 0; the first bus transfer is at cycle 1.
- Fill of N words: chipselect/write are high in cycles 1..N, done pulses in cycle N+1, and busy is high in cycles 1..N+1.
- Verify of N words: reads are issued in cycles 1..N, the last compare occurs in cycle N+READ_LATENCY, and done pulses in cycle N+READ_LATENCY+1.
- No-op (word_count = 0): done pulses in cycle 1, busy stays low, and there are no bus transfers.
- Status outputs are registered and final no later than the done cycle.
- There is no waitrequest; the RAM port accepts a transfer every cycle.

## Configuration
- NIOS2_MEMTEST_VERIFY_EN defined: READ/DRAIN states, the compare pipeline and the status counters are built, and mode 1 performs verify.
- Not defined: mode is ignored and every command is a fill. error, mismatch_count and first_fail_addr are tied to 0, and no read transfers are ever issued.

## Structure
- Package nios2_memtest_pkg holds the FSM state enum, the MODE_FILL and MODE_VERIFY constants, and the MISMATCH_MAX constant.
- Sub-module nios2_memtest_pattern_gen generates expected(i): it is loaded at start and steps once per issued transfer. The fill path and the verify path share the same instance.

## Test plan
- Fill base=0x10, count=4, pattern=0xA5A5_0000, incr=1 -> writes 0x10..0x13 with data A5A50000..A5A50003; done in cycle 5.
- Verify of the same range after the fill -> mismatch_count=0, error=0; done in cycle 4+READ_LATENCY+1.
- Corrupt word 0x12 through port s1, then verify -> mismatch_count=1, first_fail_addr=0x12, error=1.
- Fill base=0xFE, count=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 in cycles 1..4.
- word_count=0 -> done in cycle 1, chipselect never high; start pulsed while busy is ignored.
- Assert reset in cycle 3 of a 16-word fill -> all outputs 0 on the next edge; a later start runs normally.

Source files
------------

// File: rtl/nios2_memtest_pkg.sv
// Shared FSM state type and constants for the on-chip RAM memtest master.
// Verify support is controlled by NIOS2_MEMTEST_VERIFY_EN in the top-level file.
package nios2_memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic        MODE_FILL    = 1'b0;
    localparam logic        MODE_VERIFY  = 1'b1;
    localparam logic [15:0] MISMATCH_MAX = 16'hFFFF;

endpackage

// File: rtl/nios2_memtest_pattern_gen.sv
// Expected-data generator: loaded with the seed at command accept, then steps
// by 0 or 1 for every transfer issued; shared by the fill and verify paths.
module nios2_memtest_pattern_gen #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              incr_i,
    input  logic              step_i,
    output logic [DATA_W-1:0] value_o
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              incr_q, incr_d;

    always_comb begin
        value_d = value_q;
        incr_d  = incr_q;
        if (load_i) begin
            value_d = seed_i;
            incr_d  = incr_i;
        end else if (step_i) begin
            value_d = value_q + DATA_W'(incr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            incr_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            incr_q  <= incr_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/nios2_onchip_memtest_master.sv
// Avalon-MM fill/verify engine for port s2 of the dual-port on-chip RAM.
// Define NIOS2_MEMTEST_VERIFY_EN to build the read/compare path; otherwise every command is a fill.
module nios2_onchip_memtest_master
    import nios2_memtest_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   pattern,
    input  logic                incr,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         mismatch_count,
    output logic [ADDR_W-1:0]   first_fail_addr,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e              state_q;
    logic [ADDR_W:0]     remaining_q;
    logic [ADDR_W-1:0]   address_q;
    logic                cs_q, write_q, busy_q, done_q;
    logic [ADDR_W:0]     count_sat;
    logic                accept, go_verify;
    logic [DATA_W-1:0]   exp_value;

    assign count_sat = (word_count > DEPTH) ? DEPTH : word_count;
    assign accept    = (state_q == ST_IDLE) && start;

`ifdef NIOS2_MEMTEST_VERIFY_EN
    assign go_verify = (mode == MODE_VERIFY);
    logic [1:0] drain_q;
`else
    assign go_verify = 1'b0;
`endif

    nios2_memtest_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
        .clk     (clk),
        .rst     (reset),
        .load_i  (accept),
        .seed_i  (pattern),
        .incr_i  (incr),
        .step_i  (cs_q),
        .value_o (exp_value)
    );

    // remaining_q counts transfers still to issue after the one on the bus now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            address_q   <= '0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef NIOS2_MEMTEST_VERIFY_EN
            drain_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= go_verify ? ST_READ : ST_WRITE;
                            write_q     <= ~go_verify;
                            cs_q        <= 1'b1;
                            busy_q      <= 1'b1;
                            address_q   <= base_addr;
                            remaining_q <= count_sat - CNT_ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (remaining_q == '0) begin
                        state_q <= ST_DONE;
                        cs_q    <= 1'b0;
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        remaining_q <= remaining_q - CNT_ONE;
                        address_q   <= address_q + ADDR_ONE;
                    end
                end
`ifdef NIOS2_MEMTEST_VERIFY_EN
                ST_READ: begin
                    if (remaining_q == '0) begin
                        state_q <= ST_DRAIN;
                        cs_q    <= 1'b0;
                        drain_q <= 2'(READ_LATENCY - 1);
                    end else begin
                        remaining_q <= remaining_q - CNT_ONE;
                        address_q   <= address_q + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign address    = address_q;
    assign chipselect = cs_q;
    assign write      = write_q;
    assign byteenable = {(DATA_W/8){cs_q}};
    assign writedata  = exp_value;

`ifdef NIOS2_MEMTEST_VERIFY_EN
    logic [READ_LATENCY-1:0] pvld_q;
    logic [ADDR_W-1:0]       paddr_q [READ_LATENCY];
    logic [DATA_W-1:0]       pexp_q  [READ_LATENCY];
    logic                    err_q;
    logic [15:0]             mm_q;
    logic [ADDR_W-1:0]       ffa_q;

    // Expected word and address ride alongside each read until its data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pvld_q <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                paddr_q[k] <= '0;
                pexp_q[k]  <= '0;
            end
            err_q <= 1'b0;
            mm_q  <= '0;
            ffa_q <= '0;
        end else begin
            pvld_q[0]  <= cs_q & ~write_q;
            paddr_q[0] <= address_q;
            pexp_q[0]  <= exp_value;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                pvld_q[k]  <= pvld_q[k-1];
                paddr_q[k] <= paddr_q[k-1];
                pexp_q[k]  <= pexp_q[k-1];
            end
            if (accept) begin
                err_q <= 1'b0;
                mm_q  <= '0;
                ffa_q <= '0;
            end else if (pvld_q[READ_LATENCY-1] && (readdata != pexp_q[READ_LATENCY-1])) begin
                err_q <= 1'b1;
                if (mm_q != MISMATCH_MAX) mm_q <= mm_q + 16'd1;
                if (mm_q == '0) ffa_q <= paddr_q[READ_LATENCY-1];
            end
        end
    end

    assign error           = err_q;
    assign mismatch_count  = mm_q;
    assign first_fail_addr = ffa_q;
`else
    logic unused_cfg;
    assign unused_cfg      = ^{mode, readdata, READ_LATENCY == 1};
    assign error           = 1'b0;
    assign mismatch_count  = '0;
    assign first_fail_addr = '0;
`endif

endmodule
